// File: rtl/polaris_dbus_pkg.sv
// Shared definitions for the Polaris CPU data bus and its 16-bit memory bridge.
// Holds the CPU size encodings, the bridge state encoding and a helper
// that gives the number of 16-bit beats needed for each access size.
package polaris_dbus_pkg;

  localparam logic [1:0] DSIZ_BYTE  = 2'd0;
  localparam logic [1:0] DSIZ_HALF  = 2'd1;
  localparam logic [1:0] DSIZ_WORD  = 2'd2;
  localparam logic [1:0] DSIZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } dbr_state_e;

  // Number of 16-bit bus beats for an access of the given size.
  function automatic logic [2:0] dsiz_beats(input logic [1:0] siz);
    case (siz)
      DSIZ_BYTE, DSIZ_HALF: dsiz_beats = 3'd1;
      DSIZ_WORD:            dsiz_beats = 3'd2;
      default:              dsiz_beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/polaris_dbridge_ext.sv
// Combinational 64-bit load-result extender.
// Ports:
//   siz_i    - access size (DSIZ_* encoding)
//   signed_i - 1 = sign-extend, 0 = zero-extend (ignored for dword)
//   raw_i    - right-justified raw load data
//   res_o    - extended 64-bit result
module polaris_dbridge_ext
  import polaris_dbus_pkg::*;
(
  input  logic [1:0]  siz_i,
  input  logic        signed_i,
  input  logic [63:0] raw_i,
  output logic [63:0] res_o
);

  always_comb begin
    case (siz_i)
      DSIZ_BYTE: res_o = {{56{signed_i & raw_i[7]}},  raw_i[7:0]};
      DSIZ_HALF: res_o = {{48{signed_i & raw_i[15]}}, raw_i[15:0]};
      DSIZ_WORD: res_o = {{32{signed_i & raw_i[31]}}, raw_i[31:0]};
      default:   res_o = raw_i;
    endcase
  end

endmodule

// File: rtl/polaris_dbridge.sv
// Bridge from the Polaris CPU 64-bit data port to a 16-bit Wishbone-classic
// memory bus. Each CPU request becomes 1, 2 or 4 ascending bus beats; load
// data is assembled, extended and returned with a one-cycle dack_o.
// Ports:
//   clk_i, reset_i         - clock, synchronous active-high reset
//   dcyc_i/dstb_i/dwe_i    - CPU request qualifiers (request = dcyc & dstb)
//   dsiz_i/dsigned_i       - access size and load sign-extension select
//   dadr_i/ddat_i          - CPU byte address and right-justified store data
//   ddat_o/dack_o          - extended load result and completion pulse
//   wb_*                   - 16-bit Wishbone-classic master (halfword address)
module polaris_dbridge
  import polaris_dbus_pkg::*;
#(
  parameter int ADR_W = 24
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dcyc_i,
  input  logic             dstb_i,
  input  logic             dwe_i,
  input  logic [1:0]       dsiz_i,
  input  logic             dsigned_i,
  input  logic [63:0]      dadr_i,
  input  logic [63:0]      ddat_i,
  output logic [63:0]      ddat_o,
  output logic             dack_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-2:0] wb_adr_o,
  output logic [1:0]       wb_sel_o,
  output logic [15:0]      wb_dat_o,
  input  logic [15:0]      wb_dat_i,
  input  logic             wb_ack_i
);

  localparam int HW_W = ADR_W - 1;
  localparam logic [HW_W-1:0] HW_ONE = HW_W'(1);

  dbr_state_e      state_q, state_d;
  logic [HW_W-1:0] adr_q, adr_d;
  logic [1:0]      siz_q, siz_d;
  logic            sgn_q, sgn_d;
  logic            we_q, we_d;
  logic            odd_q, odd_d;
  logic [63:0]     wdat_q, wdat_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [63:0]     asm_q, asm_d;
  logic [63:0]     ddat_q, ddat_d;

  logic            req;
  logic            last_beat;
  logic [HW_W-1:0] hw_adr;
  logic [63:0]     asm_next;
  logic [63:0]     ext_res;
  logic            unused_adr_hi;

  // Bits above the bus address range are discarded.
  assign unused_adr_hi = ^dadr_i[63:ADR_W];

  assign req       = dcyc_i & dstb_i;
  assign last_beat = (({1'b0, cnt_q} + 3'd1) == dsiz_beats(siz_q));

  // Force-align the incoming address to its size, in halfword units.
  always_comb begin
    hw_adr = dadr_i[ADR_W-1:1];
    if (dsiz_i == DSIZ_WORD)  hw_adr[0]   = 1'b0;
    if (dsiz_i == DSIZ_DWORD) hw_adr[1:0] = 2'b00;
  end

  // Assembly register including the beat currently being acked.
  always_comb begin
    asm_next = asm_q;
    if (siz_q == DSIZ_BYTE) asm_next = {56'd0, (odd_q ? wb_dat_i[15:8] : wb_dat_i[7:0])};
    else                    asm_next[{cnt_q, 4'b0000} +: 16] = wb_dat_i;
  end

  polaris_dbridge_ext u_ext (
    .siz_i    (siz_q),
    .signed_i (sgn_q),
    .raw_i    (asm_next),
    .res_o    (ext_res)
  );

  // State register and datapath flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      siz_q   <= DSIZ_BYTE;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      odd_q   <= 1'b0;
      wdat_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ddat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      siz_q   <= siz_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      odd_q   <= odd_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ddat_q  <= ddat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_BEAT;
      ST_BEAT: if (wb_ack_i && last_beat) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    adr_d  = adr_q;
    siz_d  = siz_q;
    sgn_d  = sgn_q;
    we_d   = we_q;
    odd_d  = odd_q;
    wdat_d = wdat_q;
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    ddat_d = ddat_q;
    if (state_q == ST_IDLE && req) begin
      adr_d  = hw_adr;
      siz_d  = dsiz_i;
      sgn_d  = dsigned_i;
      we_d   = dwe_i;
      odd_d  = dadr_i[0];
      wdat_d = ddat_i;
      cnt_d  = 2'd0;
    end else if (state_q == ST_BEAT && wb_ack_i) begin
      if (!we_q) asm_d = asm_next;
      if (last_beat) begin
        // Stores leave the previous load result visible.
        if (!we_q) ddat_d = ext_res;
      end else begin
        adr_d = adr_q + HW_ONE;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Outputs.
  always_comb begin
    wb_cyc_o = (state_q == ST_BEAT);
    wb_stb_o = (state_q == ST_BEAT);
    wb_we_o  = (state_q == ST_BEAT) && we_q;
    wb_adr_o = '0;
    wb_sel_o = 2'b00;
    wb_dat_o = '0;
    dack_o   = (state_q == ST_DONE);
    ddat_o   = ddat_q;
    if (state_q == ST_BEAT) begin
      wb_adr_o = adr_q;
      if (siz_q == DSIZ_BYTE) begin
        wb_sel_o = odd_q ? 2'b10 : 2'b01;
        wb_dat_o = {wdat_q[7:0], wdat_q[7:0]};
      end else begin
        wb_sel_o = 2'b11;
        wb_dat_o = wdat_q[{cnt_q, 4'b0000} +: 16];
      end
    end
  end

endmodule

// File: tb/tb_polaris_dbridge.sv
// Self-checking bench for polaris_dbridge: directed cases plus randomized
// transactions checked against a size/address arithmetic reference model.
module tb_polaris_dbridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dcyc_i, dstb_i, dwe_i, dsigned_i;
  logic [1:0]  dsiz_i;
  logic [63:0] dadr_i, ddat_i;
  logic [63:0] ddat_o;
  logic        dack_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [22:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_ddat = 64'd0;

  polaris_dbridge #(.ADR_W(24)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .dcyc_i    (dcyc_i),
    .dstb_i    (dstb_i),
    .dwe_i     (dwe_i),
    .dsiz_i    (dsiz_i),
    .dsigned_i (dsigned_i),
    .dadr_i    (dadr_i),
    .ddat_i    (ddat_i),
    .ddat_o    (ddat_o),
    .dack_o    (dack_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference extension: keep the low 8<<siz bits, fill above with the sign bit
  // when requested, dword untouched.
  function automatic logic [63:0] ref_ext(input logic [63:0] raw, input logic [1:0] siz,
                                          input logic sgn);
    int bits;
    logic [63:0] mask;
    if (siz == 2'd3) return raw;
    bits = 8 << siz;
    mask = (64'd1 << bits) - 64'd1;
    if (sgn && raw[bits-1]) return (raw & mask) | ~mask;
    return raw & mask;
  endfunction

  // One complete transaction starting at a negedge in IDLE. rd supplies the
  // read halfword for beat n in rd[16n+15:16n].
  task automatic do_txn(input string tag, input logic we, input logic [1:0] siz,
                        input logic sgn, input logic [63:0] adr, input logic [63:0] wd,
                        input logic [63:0] rd, input int waits, input bit req_in_done);
    int          nb;
    logic [63:0] abyte, raw;
    logic [22:0] hw0;
    logic [1:0]  exp_sel;
    logic [15:0] exp_dat;
    nb    = (siz <= 2'd1) ? 1 : (siz == 2'd2) ? 2 : 4;
    abyte = (siz == 2'd0) ? adr : (adr & ~((64'd1 << siz) - 64'd1));
    hw0   = abyte[23:1];
    exp_sel = (siz == 2'd0) ? (adr[0] ? 2'b10 : 2'b01) : 2'b11;
    // Request cycle (IDLE); an ack here must be ignored.
    dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = we; dsiz_i = siz; dsigned_i = sgn;
    dadr_i = adr; ddat_i = wd; wb_ack_i = 1'b1; wb_dat_i = 16'($urandom);
    chk({tag, " idle cyc"}, 64'(wb_cyc_o), 64'd0);
    @(negedge clk_i);
    dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = ~we; dsiz_i = 2'($urandom);
    dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
    for (int n = 0; n < nb; n++) begin
      for (int w = 0; w <= waits; w++) begin
        chk($sformatf("%s b%0d w%0d cyc", tag, n, w), 64'({wb_cyc_o, wb_stb_o, wb_we_o}),
            64'({2'b11, we}));
        chk($sformatf("%s b%0d w%0d adr", tag, n, w), 64'(wb_adr_o), 64'(hw0 + 23'(n)));
        chk($sformatf("%s b%0d w%0d sel", tag, n, w), 64'(wb_sel_o), 64'(exp_sel));
        chk($sformatf("%s b%0d w%0d dack", tag, n, w), 64'(dack_o), 64'd0);
        if (we) begin
          exp_dat = (siz == 2'd0) ? {wd[7:0], wd[7:0]} : wd[16*n +: 16];
          chk($sformatf("%s b%0d dat", tag, n), 64'(wb_dat_o), 64'(exp_dat));
        end
        wb_ack_i = (w == waits);
        wb_dat_i = (w == waits) ? rd[16*n +: 16] : 16'($urandom);
        @(negedge clk_i);
      end
    end
    // DONE cycle: stray ack and (optionally) a request must both be ignored.
    wb_ack_i = 1'b1; wb_dat_i = 16'($urandom);
    if (req_in_done) begin
      dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'd3;
    end
    if (siz == 2'd0)  raw = {56'd0, (adr[0] ? rd[15:8] : rd[7:0])};
    else if (nb == 4) raw = rd;
    else              raw = rd & ((64'd1 << (nb * 16)) - 64'd1);
    if (!we) model_ddat = ref_ext(raw, siz, sgn);
    chk({tag, " dack"}, 64'(dack_o), 64'd1);
    chk({tag, " ddat"}, ddat_o, model_ddat);
    chk({tag, " done cyc"}, 64'(wb_cyc_o), 64'd0);
    @(negedge clk_i);
    dcyc_i = 1'b0; dstb_i = 1'b0; wb_ack_i = 1'b0;
    chk({tag, " post dack"}, 64'(dack_o), 64'd0);
    chk({tag, " post cyc"}, 64'(wb_cyc_o), 64'd0);
    chk({tag, " hold ddat"}, ddat_o, model_ddat);
  endtask

  initial begin
    logic [63:0] hw0_reset;
    reset_i = 1'b1; dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0; dsiz_i = 2'd0;
    dsigned_i = 1'b0; dadr_i = '0; ddat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset outs", 64'({dack_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    chk("reset adr", 64'(wb_adr_o), 64'd0);
    chk("reset dat", 64'(wb_dat_o), 64'd0);
    chk("reset ddat", ddat_o, 64'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Signed byte load at odd address.
    do_txn("sbyte", 1'b0, 2'd0, 1'b1, 64'h1, 64'h0, 64'h80FF, 0, 1'b0);
    chk("sbyte const", ddat_o, 64'hFFFF_FFFF_FFFF_FF80);
    // Dword store, ddat_o must remain.
    do_txn("dstore", 1'b1, 2'd3, 1'b0, 64'h100, 64'h1122_3344_5566_7788, 64'h0, 0, 1'b1);
    chk("dstore ddat", ddat_o, 64'hFFFF_FFFF_FFFF_FF80);
    // Word loads unsigned and signed.
    do_txn("wload u", 1'b0, 2'd2, 1'b0, 64'h204, 64'h0, 64'hC002_8001, 0, 1'b0);
    chk("wload u const", ddat_o, 64'h0000_0000_C002_8001);
    do_txn("wload s", 1'b0, 2'd2, 1'b1, 64'h204, 64'h0, 64'hC002_8001, 0, 1'b0);
    chk("wload s const", ddat_o, 64'hFFFF_FFFF_C002_8001);
    // Half load with three wait states.
    do_txn("hwait", 1'b0, 2'd1, 1'b1, 64'h3A, 64'h0, 64'h7123, 3, 1'b0);
    // Misaligned word forced to 0x204.
    do_txn("wmis", 1'b0, 2'd2, 1'b0, 64'h206, 64'h0, 64'h1234_5678, 1, 1'b0);
    // Byte store on even lane.
    do_txn("bstore", 1'b1, 2'd0, 1'b0, 64'hABC0, 64'h5A, 64'h0, 2, 1'b0);

    // Reset during beat 2 of a dword load.
    hw0_reset = 64'h40 >> 1;
    dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'd3; dsigned_i = 1'b0;
    dadr_i = 64'h40;
    @(negedge clk_i);
    dcyc_i = 1'b0; dstb_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF;
    @(negedge clk_i);
    chk("rst beat2 adr", 64'(wb_adr_o), hw0_reset + 64'd1);
    reset_i = 1'b1; wb_ack_i = 1'b0;
    @(negedge clk_i);
    chk("rst cyc/stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    chk("rst dack", 64'(dack_o), 64'd0);
    chk("rst ddat", ddat_o, 64'd0);
    model_ddat = 64'd0;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst after dack", 64'(dack_o), 64'd0);
    do_txn("post rst byte", 1'b0, 2'd0, 1'b0, 64'h77, 64'h0, 64'hA5C3, 0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      do_txn($sformatf("rnd%0d", t), 1'($urandom), 2'($urandom), 1'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/polaris_dbridge.md
# polaris_dbridge

Downstream neighbour of the Polaris CPU data master port. It accepts one 64-bit-wide, size-qualified load/store request from the CPU (`dcyc`/`dstb`/`dsiz`/`dsigned`) and executes it as 1, 2 or 4 beats on a 16-bit Wishbone-classic memory bus. On loads it assembles the returned halfwords and zero- or sign-extends the result to 64 bits. It then returns a single-cycle `dack` to the CPU.

## Interface
Parameters:
- `ADR_W`, default 24: byte-address width of the memory bus. Bus address bits above `ADR_W-1` are discarded.

Ports:
- `clk_i`  in  1  system clock. One clock; all state changes on its rising edge.
- `reset_i`  in  1  reset. Synchronous, active-high.
- `dcyc_i`  in  1  CPU data cycle.
- `dstb_i`  in  1  CPU data strobe. A request is `dcyc_i & dstb_i`.
- `dwe_i`  in  1  1 = store, 0 = load.
- `dsiz_i`  in  2  size encoding: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `dsigned_i`  in  1  sign-extend load result. Ignored for dword and for stores.
- `dadr_i`  in  64  byte address.
- `ddat_i`  in  64  store data, right-justified.
- `ddat_o`  out  64  load result, extended.
- `dack_o`  out  1  completion pulse to the CPU.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone controls.
- `wb_adr_o`  out  `ADR_W-1`  halfword address (byte address bits [`ADR_W-1`:1]).
- `wb_sel_o`  out  2  byte lanes. Bit 0 = [7:0] = even byte (little-endian).
- `wb_dat_o`  out  16  write data.
- `wb_dat_i`  in  16  read data.
- `wb_ack_i`  in  1  beat acknowledge.

## Operation
- States: IDLE, BEAT, DONE.
- IDLE:
  - On a request, latch address, size, signed, we and store data. Clear beat counter; go to BEAT.
  - Address is force-aligned to its size: half clears bit 0, word clears [1:0], dword clears [2:0]. No misalignment trap.
- BEAT:
  - `wb_cyc_o = wb_stb_o = 1`; `wb_we_o` = latched we.
  - Beat count: 1 for byte and half, 2 for word, 4 for dword. Beats go in ascending address order, low halfword first.
  - On `wb_ack_i`:
    - Load: store `wb_dat_i` into halfword slot *n* of the 64-bit assembly register.
    - If this was the last beat, go to DONE.
    - Otherwise increment `wb_adr_o` by 1 and the counter by 1, and stay in BEAT with `cyc`/`stb` held high.
- Byte access:
  - `wb_sel_o` = 2'b01 for an even address, 2'b10 for an odd address.
  - Store: write data is `{b,b}`.
  - Load: take the selected lane.
- Half, word and dword accesses: `wb_sel_o` = 2'b11. Store beat *n* drives `ddat_i[16n+15:16n]`.
- DONE:
  - `dack_o = 1` for exactly one cycle, with `ddat_o` valid. Return to IDLE.
  - Extension: byte uses bit 7, half bit 15, word bit 31, each when `dsigned`. Otherwise zero-extend. Dword is passed through unchanged.
  - Stores: `ddat_o` is unchanged.
- Once accepted, a request always runs to completion. `dcyc_i`/`dstb_i` are ignored until IDLE.
- `ddat_o` holds its last load value until the next load completes.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Zero-wait-state latency, request to `dack_o`:
  - byte/half: 3 cycles (IDLE, BEAT, DONE);
  - word: 4 cycles;
  - dword: 6 cycles.
- Each wait state adds one cycle per beat. `wb_adr_o`, `wb_sel_o` and `wb_dat_o` stay stable while `stb` is high and unacked.
- `wb_ack_i` is sampled only in BEAT and ignored elsewhere.
- `dack_o` rises on the cycle after the final ack. A request presented during the DONE cycle is ignored; a request present in the following IDLE cycle is accepted.
- Reset asserted mid-operation: `wb_cyc_o` and `wb_stb_o` are 0 from the next cycle. No `dack_o` is issued. The partial load is discarded.

## Structure
- Shared package `polaris_dbus_pkg` holds:
  - `DSIZ_BYTE`/`HALF`/`WORD`/`DWORD` constants;
  - the state encoding;
  - a beats-per-size function.
- Sub-module `polaris_dbridge_ext`: combinational 64-bit zero/sign extender (size, signed, raw in; result out). The CPU can reuse it.

## Test plan
- Signed byte load at 0x0001, `wb_dat_i` = 0x80FF → `wb_sel_o` = 2'b10, `wb_adr_o` = 0x0, `ddat_o` = 0xFFFF_FFFF_FFFF_FF80, `dack_o` in cycle 3.
- Dword store of 0x1122_3344_5566_7788 at 0x100, zero-wait → beats:
  - `wb_adr_o` 0x80/0x81/0x82/0x83;
  - `wb_dat_o` 7788/5566/3344/1122;
  - `sel` 11;
  - `dack_o` in cycle 6; `ddat_o` unchanged.
- Word load at 0x204 returning 0x8001 then 0xC002 → unsigned gives 0x0000_0000_C002_8001; signed gives 0xFFFF_FFFF_C002_8001.
- Half load with 3 wait states → `stb`, `adr` and `sel` stable for 4 cycles; `dack_o` exactly one cycle after the ack; total 6 cycles.
- Word load at 0x206 → executes at 0x204 (`wb_adr_o` 0x102, 0x103).
- Reset during beat 2 of a dword load → `cyc`/`stb` 0 the next cycle, no `dack_o`. A following byte load completes normally.
